// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and phase/lock enums
// for the VGA porch generator (lock FSM under VGA_PORCH_LOCK_EN).
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_VIDEO_WIDTH = 3;
  localparam int unsigned DEF_TOTAL_COLS  = 800;
  localparam int unsigned DEF_TOTAL_ROWS  = 525;
  localparam int unsigned DEF_ACTIVE_COLS = 640;
  localparam int unsigned DEF_ACTIVE_ROWS = 480;
  localparam int unsigned DEF_FP_HORZ     = 16;
  localparam int unsigned DEF_BP_HORZ     = 48;
  localparam int unsigned DEF_FP_VERT     = 10;
  localparam int unsigned DEF_BP_VERT     = 33;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_t;

  // Boundaries are exclusive upper ends of each phase.
  function automatic phase_t phase_of(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] a_end,
    input logic [CNT_W-1:0] f_end,
    input logic [CNT_W-1:0] s_end
  );
    if (cnt < a_end) return PH_ACTIVE;
    if (cnt < f_end) return PH_FRONT;
    if (cnt < s_end) return PH_SYNC;
    return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_porch_gen_if.sv
// Video bundle between upstream timing source and the porch generator.
// master drives i_* and observes o_*; slave is the generator.
interface vga_porch_gen_if #(
  parameter int unsigned VIDEO_WIDTH = 3
);

  logic                   i_HSync;
  logic                   i_VSync;
  logic [VIDEO_WIDTH-1:0] i_Red_Video;
  logic [VIDEO_WIDTH-1:0] i_Grn_Video;
  logic [VIDEO_WIDTH-1:0] i_Blu_Video;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red_Video;
  logic [VIDEO_WIDTH-1:0] o_Grn_Video;
  logic [VIDEO_WIDTH-1:0] o_Blu_Video;
  logic                   o_Locked;

  modport master (
    output i_HSync, i_VSync,
    output i_Red_Video, i_Grn_Video, i_Blu_Video,
    input  o_HSync, o_VSync,
    input  o_Red_Video, o_Grn_Video, o_Blu_Video,
    input  o_Locked
  );

  modport slave (
    input  i_HSync, i_VSync,
    input  i_Red_Video, i_Grn_Video, i_Blu_Video,
    output o_HSync, o_VSync,
    output o_Red_Video, o_Grn_Video, o_Blu_Video,
    output o_Locked
  );

endinterface

// File: rtl/vga_frame_counter.sv
// Column/row counters resynchronised by the upstream VSync
// rising edge; also flags the edge and the last frame position.
module vga_frame_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             rise,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  logic vsync_q;

  assign rise      = vsync & ~vsync_q;
  assign frame_end = (col == COL_LAST) && (row == ROW_LAST);

  // Edge restart wins over normal raster advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (rise) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_porch_gen.sv
// Porch/sync generator: blanks video outside the active area and
// emits low sync pulses; optional lock FSM via VGA_PORCH_LOCK_EN.
module vga_porch_gen
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH      = DEF_VIDEO_WIDTH,
  parameter int unsigned TOTAL_COLS       = DEF_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS       = DEF_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int unsigned FRONT_PORCH_HORZ = DEF_FP_HORZ,
  parameter int unsigned BACK_PORCH_HORZ  = DEF_BP_HORZ,
  parameter int unsigned FRONT_PORCH_VERT = DEF_FP_VERT,
  parameter int unsigned BACK_PORCH_VERT  = DEF_BP_VERT
) (
  input logic             i_Clk,
  input logic             i_Rst_L,
  vga_porch_gen_if.slave  vga
);

  localparam logic [CNT_W-1:0] H_A_END =
    CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] H_F_END =
    CNT_W'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [CNT_W-1:0] H_S_END =
    CNT_W'(TOTAL_COLS - BACK_PORCH_HORZ);
  localparam logic [CNT_W-1:0] V_A_END =
    CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] V_F_END =
    CNT_W'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [CNT_W-1:0] V_S_END =
    CNT_W'(TOTAL_ROWS - BACK_PORCH_VERT);

  logic [CNT_W-1:0]       col;
  logic [CNT_W-1:0]       row;
  logic                   rise;
  logic                   frame_end;
  logic [VIDEO_WIDTH-1:0] red_d;
  logic [VIDEO_WIDTH-1:0] grn_d;
  logic [VIDEO_WIDTH-1:0] blu_d;
  phase_t                 h_ph;
  phase_t                 v_ph;
  logic                   visible;
  logic                   unused_hsync;

  // Timing is rebuilt from VSync alone; HSync is not needed.
  assign unused_hsync = vga.i_HSync;

  vga_frame_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_cnt (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .vsync     (vga.i_VSync),
    .col       (col),
    .row       (row),
    .rise      (rise),
    .frame_end (frame_end)
  );

  assign h_ph    = phase_of(col, H_A_END, H_F_END, H_S_END);
  assign v_ph    = phase_of(row, V_A_END, V_F_END, V_S_END);
  assign visible = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);

  // Stage 1 video delay keeps pixels aligned with the counters.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      red_d <= '0;
      grn_d <= '0;
      blu_d <= '0;
    end else begin
      red_d <= vga.i_Red_Video;
      grn_d <= vga.i_Grn_Video;
      blu_d <= vga.i_Blu_Video;
    end
  end

  // Stage 2 registered syncs and blanked video.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      vga.o_HSync     <= 1'b1;
      vga.o_VSync     <= 1'b1;
      vga.o_Red_Video <= '0;
      vga.o_Grn_Video <= '0;
      vga.o_Blu_Video <= '0;
    end else begin
      vga.o_HSync     <= (h_ph != PH_SYNC);
      vga.o_VSync     <= (v_ph != PH_SYNC);
      vga.o_Red_Video <= visible ? red_d : '0;
      vga.o_Grn_Video <= visible ? grn_d : '0;
      vga.o_Blu_Video <= visible ? blu_d : '0;
    end
  end

`ifdef VGA_PORCH_LOCK_EN
  lock_t state;
  lock_t state_nx;
  logic  tally;
  logic  tally_nx;

  // Lock state and good-edge tally register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= UNLOCKED;
      tally <= 1'b0;
    end else begin
      state <= state_nx;
      tally <= tally_nx;
    end
  end

  // Two back-to-back on-time edges lock; any late/early edge unlocks.
  always_comb begin
    state_nx = state;
    tally_nx = tally;
    if (rise) begin
      if (!frame_end) begin
        state_nx = UNLOCKED;
        tally_nx = 1'b0;
      end else if (state == UNLOCKED) begin
        if (tally) begin
          state_nx = LOCKED;
          tally_nx = 1'b0;
        end else begin
          tally_nx = 1'b1;
        end
      end
    end
  end

  assign vga.o_Locked = (state == LOCKED);
`else
  logic unused_lock;

  assign unused_lock = rise ^ frame_end;

  // No tracking: reports locked whenever out of reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) vga.o_Locked <= 1'b0;
    else          vga.o_Locked <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vga_porch_gen.sv
// Randomised bench: a scaled and a default-timing generator share one
// upstream source and are compared to a linear-position raster model.
module tb_vga_porch_gen;
  import vga_pkg::*;

  localparam int unsigned UP_COLS = 40;
  localparam int unsigned UP_ROWS = 20;
  localparam int unsigned UP_N    = UP_COLS * UP_ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_porch_gen_if #(.VIDEO_WIDTH(3)) sbus ();
  vga_porch_gen_if #(.VIDEO_WIDTH(3)) dbus ();

  vga_porch_gen #(
    .VIDEO_WIDTH      (3),
    .TOTAL_COLS       (40),
    .TOTAL_ROWS       (20),
    .ACTIVE_COLS      (32),
    .ACTIVE_ROWS      (16),
    .FRONT_PORCH_HORZ (2),
    .BACK_PORCH_HORZ  (4),
    .FRONT_PORCH_VERT (1),
    .BACK_PORCH_VERT  (2)
  ) u_small (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .vga     (sbus)
  );

  vga_porch_gen u_dflt (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .vga     (dbus)
  );

  // Per-instance timing: [0] scaled, [1] default 800x525.
  int unsigned tc[2]   = '{40, 800};
  int unsigned tr[2]   = '{20, 525};
  int unsigned ac[2]   = '{32, 640};
  int unsigned ar[2]   = '{16, 480};
  int unsigned h_lo[2] = '{34, 656};
  int unsigned h_hi[2] = '{36, 752};
  int unsigned v_lo[2] = '{17, 490};
  int unsigned v_hi[2] = '{18, 492};

  int unsigned pos[2];
  int unsigned streak[2];
  logic        exp_hs[2];
  logic        exp_vs[2];
  logic        exp_lk[2];
  logic [8:0]  exp_vid[2];
  logic        m_vsq;
  logic [8:0]  m_vd;
  int unsigned up;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after one edge, from raster position arithmetic.
  task automatic model_edge(input logic rst, input logic vs,
                            input logic [8:0] vid);
    logic rise;
    int unsigned c, r;
    rise = vs && !m_vsq;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        exp_hs[k] = 1'b1; exp_vs[k] = 1'b1;
        exp_vid[k] = '0; exp_lk[k] = 1'b0;
        pos[k] = 0; streak[k] = 0;
      end else begin
        c = pos[k] % tc[k];
        r = pos[k] / tc[k];
        exp_hs[k] = !(c >= h_lo[k] && c < h_hi[k]);
        exp_vs[k] = !(r >= v_lo[k] && r < v_hi[k]);
        exp_vid[k] = (c < ac[k] && r < ar[k]) ? m_vd : 9'd0;
        if (rise) begin
          if (pos[k] == tc[k] * tr[k] - 1)
            streak[k] = (streak[k] < 2) ? streak[k] + 1 : 2;
          else
            streak[k] = 0;
        end
`ifdef VGA_PORCH_LOCK_EN
        exp_lk[k] = (streak[k] >= 2);
`else
        exp_lk[k] = 1'b1;
`endif
        pos[k] = rise ? 0 : (pos[k] + 1) % (tc[k] * tr[k]);
      end
    end
    m_vsq = rst ? vs : 1'b0;
    m_vd  = rst ? vid : 9'd0;
  endtask

  task automatic step(input logic rst, input logic hs,
                      input logic vs, input logic [8:0] vid);
    rst_n = rst;
    sbus.i_HSync = hs; dbus.i_HSync = hs;
    sbus.i_VSync = vs; dbus.i_VSync = vs;
    {sbus.i_Red_Video, sbus.i_Grn_Video, sbus.i_Blu_Video} = vid;
    {dbus.i_Red_Video, dbus.i_Grn_Video, dbus.i_Blu_Video} = vid;
    @(posedge clk);
    model_edge(rst, vs, vid);
    @(negedge clk);
    chk("s.hsync", 32'(sbus.o_HSync), 32'(exp_hs[0]));
    chk("s.vsync", 32'(sbus.o_VSync), 32'(exp_vs[0]));
    chk("s.video", 32'({sbus.o_Red_Video, sbus.o_Grn_Video,
                        sbus.o_Blu_Video}), 32'(exp_vid[0]));
    chk("s.lock", 32'(sbus.o_Locked), 32'(exp_lk[0]));
    chk("d.hsync", 32'(dbus.o_HSync), 32'(exp_hs[1]));
    chk("d.vsync", 32'(dbus.o_VSync), 32'(exp_vs[1]));
    chk("d.video", 32'({dbus.o_Red_Video, dbus.o_Grn_Video,
                        dbus.o_Blu_Video}), 32'(exp_vid[1]));
    chk("d.lock", 32'(dbus.o_Locked), 32'(exp_lk[1]));
  endtask

  // One upstream pixel; kill_vs drops VSync to inject a rogue edge.
  task automatic up_cycle(input logic rst, input bit rnd,
                          input bit kill_vs);
    logic hs, vs;
    logic [8:0] vid;
    hs  = (up % UP_COLS) < 32;
    vs  = (up / UP_COLS) < 16 && !kill_vs;
    vid = rnd ? 9'($urandom) : 9'h1FF;
    step(rst, hs, vs, vid);
    up = (up + 1) % UP_N;
  endtask

  initial begin
    m_vsq = 1'b0;
    m_vd  = '0;
    up    = 0;
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; streak[k] = 0;
    end
    @(negedge clk);
    repeat (5) step(1'b0, 1'($urandom), 1'($urandom), 9'($urandom));
    repeat (3 * UP_N) up_cycle(1'b1, 1'b0, 1'b0);
    while (up != 5 * UP_COLS + 10) up_cycle(1'b1, 1'b1, 1'b0);
    up_cycle(1'b1, 1'b1, 1'b1);
    repeat (4 * UP_N) up_cycle(1'b1, 1'b1, 1'b0);
    while (up != 400) up_cycle(1'b1, 1'b1, 1'b0);
    repeat (3) up_cycle(1'b0, 1'b1, 1'b0);
    repeat (4 * UP_N) up_cycle(1'b1, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_porch_gen.md
VGA_PORCH_GEN -- requirements
Module: vga_porch_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- VIDEO_WIDTH, 3, bits per colour channel
- TOTAL_COLS, 800, columns per line
- TOTAL_ROWS, 525, rows per frame
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- FRONT_PORCH_HORZ, 16, horizontal front porch
- BACK_PORCH_HORZ, 48, horizontal back porch
- FRONT_PORCH_VERT, 10, vertical front porch
- BACK_PORCH_VERT, 33, vertical back porch
REQ-002 Ports (name, direction, width, meaning), one per line; reset is synchronous and active-low:
- i_Clk, in, 1, pixel clock
- i_Rst_L, in, 1, reset
- i_HSync, in, 1, upstream active-high horizontal active-area flag
- i_VSync, in, 1, upstream active-high vertical active-area flag
- i_Red_Video, in, VIDEO_WIDTH, red
- i_Grn_Video, in, VIDEO_WIDTH, green
- i_Blu_Video, in, VIDEO_WIDTH, blue
- o_HSync, out, 1, porch-adjusted horizontal sync, active-low pulse
- o_VSync, out, 1, porch-adjusted vertical sync, active-low pulse
- o_Red_Video, out, VIDEO_WIDTH, blanked red
- o_Grn_Video, out, VIDEO_WIDTH, blanked green
- o_Blu_Video, out, VIDEO_WIDTH, blanked blue
- o_Locked, out, 1, frame-lock status

Function
REQ-003 Stage 1 registers the 10-bit column and row counters, a 1-cycle i_VSync history, and the 1-cycle-delayed video.
REQ-004 Rising edge of i_VSync (current 1, previous 0) forces col=0 and row=0 on the next cycle, overriding normal counting.
REQ-005 Otherwise col increments each cycle; at col==TOTAL_COLS-1, col wraps to 0 and row increments; at row==TOTAL_ROWS-1 with col wrap, row wraps to 0.
REQ-006 Horizontal phase is H_ACTIVE (col<ACTIVE_COLS), H_FRONT (<ACTIVE_COLS+FRONT_PORCH_HORZ), H_SYNC (<TOTAL_COLS-BACK_PORCH_HORZ), H_BACK (otherwise); vertical V_* phases are defined the same way with row and the vertical parameters.
REQ-007 Stage 2 registers the outputs: o_HSync=0 only in H_SYNC; o_VSync=0 only in V_SYNC; with defaults, low for col 656..751 (96 cycles) and row 490..491.
REQ-008 Stage 2 passes video when H_ACTIVE and V_ACTIVE, else drives 0 on all three channels.
REQ-009 Latency from i_*Video to o_*Video is exactly 2 cycles; o_HSync/o_VSync are aligned with the video of the same column/row.
REQ-010 Counter comparisons are unsigned; parameter products/sums are evaluated at elaboration; no negative intermediate values.

Reset
REQ-011 While i_Rst_L=0 at a clock edge: counters=0, VSync history=0, o_HSync=1, o_VSync=1, video outputs=0, o_Locked=0.
REQ-012 Reset asserted mid-frame takes effect on the next edge; after release, counting resumes from 0 and the first i_VSync rising edge resynchronises.

Configuration
REQ-013 With VGA_PORCH_LOCK_EN defined: a lock FSM has states UNLOCKED and LOCKED.
- Good edge: an i_VSync rising edge coinciding with col==TOTAL_COLS-1 and row==TOTAL_ROWS-1.
- Two consecutive good edges: UNLOCKED -> LOCKED.
- Any rising edge at another count: -> UNLOCKED and the good-edge tally clears.
- o_Locked=1 in LOCKED.
REQ-014 Without VGA_PORCH_LOCK_EN: no lock FSM; o_Locked is tied to 1.

Structure
REQ-015 Package vga_pkg holds the default timing constants and the h/v phase enumeration.
REQ-016 Counter/edge logic lives in one sub-module, vga_frame_counter; the phase decode, the output registers and the lock FSM live in vga_porch_gen.

Verification
REQ-017 Reset held for 5 cycles with arbitrary inputs -> o_HSync=1, o_VSync=1, video=0, o_Locked=0.
REQ-018 Upstream 800x525 timing with constant video 3'b111 -> white for col 0..639 of rows 0..479, 0 elsewhere, delayed exactly 2 cycles.
REQ-019 Same stimulus -> o_HSync low exactly 96 cycles per line starting at col 656; o_VSync low exactly rows 490..491.
REQ-020 i_VSync rising edge injected at col 300, row 100 -> counters restart at 0; with VGA_PORCH_LOCK_EN, o_Locked drops to 0 and returns to 1 after two clean frames.
REQ-021 Reset pulsed mid-line at col 400 -> outputs return to reset values, then correct timing from the next i_VSync rising edge.
REQ-022 Build without VGA_PORCH_LOCK_EN -> o_Locked=1 after reset release; all other checks unchanged.
